// File: rtl/core_pkg.sv
// Shared core definitions: register index width, hazard FSM encoding and the
// grouped pipeline enable/flush controls driven by the hazard unit.
package core_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int FLUSH_CNT_W = 2;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_FLUSH   = 2'd1,
    HZ_MC_WAIT = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_bubble;
  } pipe_ctrl_t;

  // Free-running pipeline: every register advances, nothing squashed.
  localparam pipe_ctrl_t PIPE_RUN = '{
    pc_write:      1'b1,
    if_id_write:   1'b1,
    if_id_flush:   1'b0,
    id_ex_write:   1'b1,
    id_ex_bubble:  1'b0,
    ex_mem_bubble: 1'b0
  };

endpackage

// File: rtl/hazard_perf_counters.sv
// Wrapping 32-bit event counters for load-use bubbles, flushed fetch cycles
// and multi-cycle stall cycles. Only instantiated under HAZ_PERF_CNT_EN.
module hazard_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_stall,
  input  logic        flush,
  input  logic        mc_wait,
  output logic [31:0] load_stalls,
  output logic [31:0] flush_cycles,
  output logic [31:0] mc_cycles
);

  always_ff @(posedge clk) begin
    if (rst) begin
      load_stalls  <= '0;
      flush_cycles <= '0;
      mc_cycles    <= '0;
    end else begin
      if (load_stall) load_stalls  <= load_stalls + 32'd1;
      if (flush)      flush_cycles <= flush_cycles + 32'd1;
      if (mc_wait)    mc_cycles    <= mc_cycles + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use / redirect-flush / multi-cycle-EX stall controller for the 5-stage
// core. Optional performance counters are enabled with macro HAZ_PERF_CNT_EN.
module hazard_control_unit
  import core_pkg::*;
#(
  parameter int REG_ADDR_W   = core_pkg::REG_ADDR_W,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_ex_memread,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  ex_redirect,
  input  logic                  ex_mc_start,
  input  logic                  ex_mc_done,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_write,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_bubble,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0]           perf_load_stalls,
  output logic [31:0]           perf_flush_cycles,
  output logic [31:0]           perf_mc_cycles,
`endif
  output logic [1:0]            state_o
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  hz_state_t              state;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  pipe_ctrl_t             ctrl;
  logic                   load_use;
  logic                   mc_enter;
  logic                   load_stall;

  // x0 is hardwired zero, so a load targeting it can never create a hazard.
  assign load_use = id_ex_memread && (id_ex_rd != '0) &&
                    ((id_uses_rs1 && (id_ex_rd == id_rs1)) ||
                     (id_uses_rs2 && (id_ex_rd == id_rs2)));
  assign mc_enter   = ex_mc_start && !ex_mc_done;
  assign load_stall = (state == HZ_RUN) && !ex_redirect && !mc_enter && load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HZ_RUN;
      flush_cnt <= '0;
    end else begin
      case (state)
        HZ_RUN: begin
          if (ex_redirect) begin
            if (FLUSH_CYCLES > 1) begin
              state     <= HZ_FLUSH;
              flush_cnt <= FLUSH_RELOAD;
            end
          end else if (mc_enter) begin
            state <= HZ_MC_WAIT;
          end
        end
        HZ_FLUSH: begin
          if (ex_redirect) begin
            flush_cnt <= FLUSH_RELOAD;
          end else if (flush_cnt <= FLUSH_CNT_W'(1)) begin
            state     <= HZ_RUN;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt - FLUSH_CNT_W'(1);
          end
        end
        // EX is frozen here, so any ex_redirect seen is stale and ignored.
        HZ_MC_WAIT: if (ex_mc_done) state <= HZ_RUN;
        default: begin
          state     <= HZ_RUN;
          flush_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    ctrl = PIPE_RUN;
    case (state)
      HZ_RUN: begin
        if (ex_redirect) begin
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end else if (load_stall) begin
          ctrl.pc_write     = 1'b0;
          ctrl.if_id_write  = 1'b0;
          ctrl.id_ex_bubble = 1'b1;
        end
      end
      HZ_FLUSH: begin
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_bubble = 1'b1;
      end
      HZ_MC_WAIT: begin
        // The done cycle releases the freeze immediately.
        if (!ex_mc_done) begin
          ctrl.pc_write      = 1'b0;
          ctrl.if_id_write   = 1'b0;
          ctrl.id_ex_write   = 1'b0;
          ctrl.ex_mem_bubble = 1'b1;
        end
      end
      default: ctrl = PIPE_RUN;
    endcase
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_write   = ctrl.id_ex_write;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_mem_bubble = ctrl.ex_mem_bubble;
  assign state_o       = state;

`ifdef HAZ_PERF_CNT_EN
  hazard_perf_counters u_perf (
    .clk          (clk),
    .rst          (rst),
    .load_stall   (load_stall),
    .flush        (ctrl.if_id_flush),
    .mc_wait      (state == HZ_MC_WAIT),
    .load_stalls  (perf_load_stalls),
    .flush_cycles (perf_flush_cycles),
    .mc_cycles    (perf_mc_cycles)
  );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: instance a uses FLUSH_CYCLES=2 and
// instance b FLUSH_CYCLES=1, both driven by the same inputs.
module tb_hazard_control_unit;

  localparam int RW = 5;
  // Control order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble
  localparam logic [5:0] NORM = 6'b110100;
  localparam logic [5:0] LU   = 6'b000110;
  localparam logic [5:0] RED  = 6'b111110;
  localparam logic [5:0] MCF  = 6'b000001;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rs1, id_rs2, id_ex_rd;
  logic          id_uses_rs1, id_uses_rs2, id_ex_memread;
  logic          ex_redirect, ex_mc_start, ex_mc_done;

  logic       pc_write_a, if_id_write_a, if_id_flush_a, id_ex_write_a, id_ex_bubble_a, ex_mem_bubble_a;
  logic       pc_write_b, if_id_write_b, if_id_flush_b, id_ex_write_b, id_ex_bubble_b, ex_mem_bubble_b;
  logic [1:0] state_a, state_b;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_ld_a, perf_fl_a, perf_mc_a, perf_ld_b, perf_fl_b, perf_mc_b;
  int unsigned m_ld, m_fl, m_mc;
`endif

  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_W(RW), .FLUSH_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .pc_write(pc_write_a), .if_id_write(if_id_write_a), .if_id_flush(if_id_flush_a),
    .id_ex_write(id_ex_write_a), .id_ex_bubble(id_ex_bubble_a), .ex_mem_bubble(ex_mem_bubble_a),
`ifdef HAZ_PERF_CNT_EN
    .perf_load_stalls(perf_ld_a), .perf_flush_cycles(perf_fl_a), .perf_mc_cycles(perf_mc_a),
`endif
    .state_o(state_a)
  );

  hazard_control_unit #(.REG_ADDR_W(RW), .FLUSH_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .pc_write(pc_write_b), .if_id_write(if_id_write_b), .if_id_flush(if_id_flush_b),
    .id_ex_write(id_ex_write_b), .id_ex_bubble(id_ex_bubble_b), .ex_mem_bubble(ex_mem_bubble_b),
`ifdef HAZ_PERF_CNT_EN
    .perf_load_stalls(perf_ld_b), .perf_flush_cycles(perf_fl_b), .perf_mc_cycles(perf_mc_b),
`endif
    .state_o(state_b)
  );

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_ex_memread = 1'b0;
    ex_redirect = 1'b0; ex_mc_start = 1'b0; ex_mc_done = 1'b0;
  endtask

  task automatic load_in_ex(input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                            input logic [RW-1:0] rs2, input logic u1, input logic u2);
    id_ex_memread = 1'b1; id_ex_rd = rd;
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
  endtask

  // Push the expected {state, controls} of both instances, compare at negedge, advance.
  task automatic cycle(input string tag, input logic [7:0] exp_a, input logic [7:0] exp_b);
    logic [15:0] e;
    string       t;
    logic [7:0]  obs_a, obs_b;
    exp_q.push_back({exp_a, exp_b});
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    obs_a = {state_a, pc_write_a, if_id_write_a, if_id_flush_a, id_ex_write_a, id_ex_bubble_a, ex_mem_bubble_a};
    obs_b = {state_b, pc_write_b, if_id_write_b, if_id_flush_b, id_ex_write_b, id_ex_bubble_b, ex_mem_bubble_b};
    chk_cnt++;
    assert (obs_a === e[15:8]) pass_cnt++;
    else $error("FAIL %s/a observed=%b expected=%b", t, obs_a, e[15:8]);
    chk_cnt++;
    assert (obs_b === e[7:0]) pass_cnt++;
    else $error("FAIL %s/b observed=%b expected=%b", t, obs_b, e[7:0]);
`ifdef HAZ_PERF_CNT_EN
    if (rst) begin
      m_ld = 0; m_fl = 0; m_mc = 0;
    end else begin
      if (e[13:8] == LU) m_ld++;
      if (e[11])         m_fl++;
      if (e[15:14] == 2'd2) m_mc++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
`ifdef HAZ_PERF_CNT_EN
    m_ld = 0; m_fl = 0; m_mc = 0;
`endif
    @(posedge clk); #1;
    cycle("reset", {2'd0, NORM}, {2'd0, NORM});
    rst = 1'b0;

    // Load-use on rs1, then the bubble clears the load
    load_in_ex(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    cycle("lu_rs1", {2'd0, LU}, {2'd0, LU});
    idle();
    cycle("lu_rs1_after", {2'd0, NORM}, {2'd0, NORM});
    load_in_ex(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    cycle("lu_x0", {2'd0, NORM}, {2'd0, NORM});
    load_in_ex(5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
    cycle("lu_rs2", {2'd0, LU}, {2'd0, LU});
    load_in_ex(5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
    cycle("lu_rs2_unused", {2'd0, NORM}, {2'd0, NORM});
    idle();

    // Redirect pulse
    ex_redirect = 1'b1;
    cycle("redir", {2'd0, RED}, {2'd0, RED});
    idle();
    cycle("redir_flush", {2'd1, RED}, {2'd0, NORM});
    cycle("redir_done", {2'd0, NORM}, {2'd0, NORM});

    // Second redirect while flushing reloads the counter
    ex_redirect = 1'b1;
    cycle("redir2_first", {2'd0, RED}, {2'd0, RED});
    cycle("redir2_reload", {2'd1, RED}, {2'd0, RED});
    idle();
    cycle("redir2_tail", {2'd1, RED}, {2'd0, NORM});
    cycle("redir2_done", {2'd0, NORM}, {2'd0, NORM});

    // Multi-cycle op finishing 4 cycles after start
    ex_mc_start = 1'b1;
    cycle("mc_start", {2'd0, NORM}, {2'd0, NORM});
    idle();
    for (int i = 0; i < 3; i++) cycle("mc_wait", {2'd2, MCF}, {2'd2, MCF});
    ex_mc_done = 1'b1;
    cycle("mc_release", {2'd2, NORM}, {2'd2, NORM});
    idle();
    cycle("mc_back_run", {2'd0, NORM}, {2'd0, NORM});

    // Single-cycle completion never stalls
    ex_mc_start = 1'b1; ex_mc_done = 1'b1;
    cycle("mc_single", {2'd0, NORM}, {2'd0, NORM});
    idle();
    cycle("mc_single_after", {2'd0, NORM}, {2'd0, NORM});

    // Redirect beats multi-cycle start and load-use
    ex_redirect = 1'b1; ex_mc_start = 1'b1;
    load_in_ex(5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
    cycle("prio_all", {2'd0, RED}, {2'd0, RED});
    idle();
    cycle("prio_all_next", {2'd1, RED}, {2'd0, NORM});
    cycle("prio_all_done", {2'd0, NORM}, {2'd0, NORM});

    // Multi-cycle start beats load-use, load-use re-evaluated after release
    ex_mc_start = 1'b1;
    load_in_ex(5'd4, 5'd4, 5'd0, 1'b1, 1'b0);
    cycle("prio_mc_lu", {2'd0, NORM}, {2'd0, NORM});
    ex_mc_start = 1'b0;
    cycle("prio_mc_wait", {2'd2, MCF}, {2'd2, MCF});
    ex_mc_done = 1'b1;
    cycle("prio_mc_rel", {2'd2, NORM}, {2'd2, NORM});
    ex_mc_done = 1'b0;
    cycle("prio_lu_after", {2'd0, LU}, {2'd0, LU});
    idle();
    cycle("prio_lu_clear", {2'd0, NORM}, {2'd0, NORM});

    // Redirect ignored while frozen
    ex_mc_start = 1'b1;
    cycle("mcr_start", {2'd0, NORM}, {2'd0, NORM});
    idle();
    ex_redirect = 1'b1;
    cycle("mcr_ignored", {2'd2, MCF}, {2'd2, MCF});
    ex_redirect = 1'b0; ex_mc_done = 1'b1;
    cycle("mcr_release", {2'd2, NORM}, {2'd2, NORM});
    idle();
    cycle("mcr_run", {2'd0, NORM}, {2'd0, NORM});

    // Reset on MC_WAIT cycle 2
    ex_mc_start = 1'b1;
    cycle("rmc_start", {2'd0, NORM}, {2'd0, NORM});
    idle();
    cycle("rmc_wait1", {2'd2, MCF}, {2'd2, MCF});
    rst = 1'b1;
    cycle("rmc_wait2_rst", {2'd2, MCF}, {2'd2, MCF});
    rst = 1'b0;
    cycle("rmc_after_rst", {2'd0, NORM}, {2'd0, NORM});

    // Reset mid-flush
    ex_redirect = 1'b1;
    cycle("rfl_redir", {2'd0, RED}, {2'd0, RED});
    idle();
    rst = 1'b1;
    cycle("rfl_flush_rst", {2'd1, RED}, {2'd0, NORM});
    rst = 1'b0;
    cycle("rfl_after_rst", {2'd0, NORM}, {2'd0, NORM});

    // Counter workload after the last reset: 3 load bubbles, 2 flush cycles, 4 MC cycles
    for (int i = 0; i < 3; i++) begin
      load_in_ex(5'(i + 1), 5'(i + 1), 5'd0, 1'b1, 1'b0);
      cycle("pc_lu", {2'd0, LU}, {2'd0, LU});
      idle();
      cycle("pc_lu_clear", {2'd0, NORM}, {2'd0, NORM});
    end
    ex_redirect = 1'b1;
    cycle("pc_redir", {2'd0, RED}, {2'd0, RED});
    idle();
    cycle("pc_flush", {2'd1, RED}, {2'd0, NORM});
    ex_mc_start = 1'b1;
    cycle("pc_mc_start", {2'd0, NORM}, {2'd0, NORM});
    idle();
    for (int i = 0; i < 3; i++) cycle("pc_mc_wait", {2'd2, MCF}, {2'd2, MCF});
    ex_mc_done = 1'b1;
    cycle("pc_mc_rel", {2'd2, NORM}, {2'd2, NORM});
    idle();

`ifdef HAZ_PERF_CNT_EN
    chk_cnt++;
    assert (perf_ld_a === 32'd3 && m_ld == 3) pass_cnt++;
    else $error("FAIL perf_load observed=%0d expected=3", perf_ld_a);
    chk_cnt++;
    assert (perf_fl_a === 32'd2 && m_fl == 2) pass_cnt++;
    else $error("FAIL perf_flush observed=%0d expected=2", perf_fl_a);
    chk_cnt++;
    assert (perf_mc_a === 32'd4 && m_mc == 4) pass_cnt++;
    else $error("FAIL perf_mc observed=%0d expected=4", perf_mc_a);
`endif

    if (exp_q.size() != 0) begin
      chk_cnt++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline hazard and stall controller for the 5-stage RV32 core. It sits beside the EX-stage forwarding logic and drives the PC and IF/ID, ID/EX and EX/MEM register enables and flushes. It covers three cases that forwarding cannot resolve: load-use hazards, taken-branch/jump flushes, and multi-cycle EX operations (mul/div). It holds a small FSM plus a flush counter, and optional performance counters.

Parameters:
REG_ADDR_W, 5, register-index width
FLUSH_CYCLES, 1, fetch-side cycles squashed after a taken redirect (1..3)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_rs1  in  REG_ADDR_W  rs1 index of instruction in ID
id_rs2  in  REG_ADDR_W  rs2 index of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_ex_memread  in  1  instruction in EX is a load
id_ex_rd  in  REG_ADDR_W  destination of instruction in EX
ex_redirect  in  1  taken branch/jump resolved in EX this cycle
ex_mc_start  in  1  multi-cycle op entering EX this cycle
ex_mc_done  in  1  multi-cycle unit result valid this cycle
pc_write  out  1  PC register enable
if_id_write  out  1  IF/ID enable
if_id_flush  out  1  IF/ID load NOP
id_ex_write  out  1  ID/EX enable
id_ex_bubble  out  1  ID/EX load zeroed controls
ex_mem_bubble  out  1  EX/MEM load zeroed controls
state_o  out  2  current FSM state (debug)

Behaviour:
- States: RUN=0, FLUSH=1, MC_WAIT=2. Reset → RUN, flush counter=0.
- Reset values: pc_write=1, if_id_write=1, id_ex_write=1, all flush/bubble outputs=0. Outputs are combinational from state and inputs.
- Load-use (RUN only): id_ex_memread && id_ex_rd!=0 && ((id_uses_rs1 && id_ex_rd==id_rs1) || (id_uses_rs2 && id_ex_rd==id_rs2)).
  - In that cycle: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - Exactly one bubble per load. No state change; the bubble clears id_ex_memread on the next cycle.
- Redirect (any state except MC_WAIT): ex_redirect=1 → if_id_flush=1, id_ex_bubble=1, pc_write=1.
  - FLUSH_CYCLES>1: go to FLUSH with counter=FLUSH_CYCLES-1.
  - FLUSH_CYCLES==1: stay in RUN.
- FLUSH: if_id_flush=1, id_ex_bubble=1 each cycle; counter decrements; counter==1 → RUN next cycle. A new ex_redirect in FLUSH reloads the counter.
- Multi-cycle: RUN && ex_mc_start && !ex_mc_done → MC_WAIT.
  - MC_WAIT: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1.
  - ex_mc_done=1 in MC_WAIT: release the freeze that same cycle (all enables 1, ex_mem_bubble=0) and return to RUN.
  - ex_mc_start together with ex_mc_done (single-cycle completion) → no stall.
- Priority in RUN: ex_redirect > multi-cycle start > load-use.
  - Redirect together with ex_mc_start: redirect wins, no MC_WAIT entry.
  - Load-use together with ex_mc_start: MC_WAIT entry wins. Load-use is then re-evaluated after release.
- ex_redirect is ignored in MC_WAIT (EX is frozen, so it cannot be valid).
- rst asserted mid-FLUSH or mid-MC_WAIT → RUN and reset outputs on the next edge; the counter clears.
- Register x0 never causes a load-use stall.

Optional Feature:
Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs perf_load_stalls, perf_flush_cycles and perf_mc_cycles, each 32 bits.
  - They increment on each load-use bubble cycle, each cycle if_id_flush=1, and each MC_WAIT cycle respectively.
  - They wrap at 2^32, reset to 0, and increment in the same cycle as the event, visible on the next edge.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg holds:
  - REG_ADDR_W
  - the hazard state encoding (HZ_RUN, HZ_FLUSH, HZ_MC_WAIT)
  - a pipe_ctrl_t struct grouping the six enable/flush outputs
- One natural sub-module, hazard_perf_counters, instantiated only under HAZ_PERF_CNT_EN.

Test Plan:
- lw x5 in EX, ID uses rs1=x5 → one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, then all enables 1. Repeat with rd=x0 → no stall.
- ex_redirect pulse with FLUSH_CYCLES=2 → if_id_flush=1 for 2 consecutive cycles, state_o 0→1→0. Second redirect in FLUSH extends the flush by 2 more cycles.
- ex_mc_start, ex_mc_done 4 cycles later → MC_WAIT for 4 cycles with id_ex_write=0, ex_mem_bubble=1; release in the done cycle.
- Same-cycle ex_redirect + ex_mc_start + load-use → only the redirect response, state_o stays 0 (FLUSH_CYCLES=1).
- rst asserted on MC_WAIT cycle 2 → next cycle state_o=0 and all enables 1.
- HAZ_PERF_CNT_EN: 3 load-use stalls, 2 flush cycles, 4 MC cycles → counters read 3/2/4. Preload near 2^32-1 → wraps to 0.
